// File: rtl/dmem_pkg.sv
// dmem_pkg: shared arbiter state type, port identifiers and byte-address helpers
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, SERVE, LOCK} state_t;
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DMA  = 1'b1;
   // Word aligned and inside a memory of 2**aw words.
   function automatic logic addr_ok(input logic [31:0] addr, input int aw);
      return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
   endfunction
   // Word index, zero-extended to 32 bits.
   function automatic logic [31:0] word_idx(input logic [31:0] addr, input int aw);
      return (addr >> 2) & ((32'd1 << aw) - 32'd1);
   endfunction
endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check: combinational alignment/range check and word index of a byte address
//   addr  in   byte address of the granted request
//   ok    out  1 = word aligned and inside the memory
//   word  out  word index, zero-extended to 32 bits
module dmem_addr_check
   import dmem_pkg::*;
#(
   parameter int AW = 6
) (
   input  logic [31:0] addr,
   output logic        ok,
   output logic [31:0] word
);
   assign ok   = addr_ok(addr, AW);
   assign word = word_idx(addr, AW);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (port 0) and a DMA/debug loader (port 1)
//   clk, rst    clock; asynchronous active-high reset
//   p0_*, p1_*  valid/ready request (we, byte addr, wdata); registered rvalid/rdata/err one cycle after accept
//   dma_lock    DMA asks for back-to-back ownership, bounded to MAX_BURST consecutive grants
//   mem_*       memory MemRead/MemWrite, word address, write data; mem_rdata is combinational read data
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH     = 64,
   parameter int AW        = $clog2(DEPTH),
   parameter int MAX_BURST = 8,
   parameter int CORE_PRIO = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_valid,
   output logic        p0_ready,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_valid,
   output logic        p1_ready,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   input  logic        dma_lock,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam int            BW        = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   state_t        state, state_nx;
   logic          rr_last, rr_nx, idle, idle_nx, g0, g1, we, ok, acc;
   logic [BW-1:0] cnt, cnt_nx;
   logic [31:0]   addr, wdata, word;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idle_nx  = idle;
      g0       = 1'b0;
      g1       = 1'b0;
      if (state == LOCK) begin
         g1      = p1_valid;
         cnt_nx  = g1 ? cnt + 1'b1 : cnt;
         idle_nx = !p1_valid;
         // Lock dropped, burst budget spent, or DMA idle for a second cycle running.
         if (!dma_lock || (g1 && cnt_nx == BURST_MAX) || (!p1_valid && idle)) begin
            state_nx = SERVE;
            cnt_nx   = '0;
            idle_nx  = 1'b0;
         end
      end else begin
         // rr_last is the previous winner, so a conflict goes to the other port unless the core has priority.
         g0       = p0_valid && (!p1_valid || CORE_PRIO != 0 || rr_last == PORT_DMA);
         g1       = p1_valid && !g0;
         state_nx = (g0 || g1) ? SERVE : IDLE;
         if (g1 && dma_lock && MAX_BURST > 1) begin
            state_nx = LOCK;
            cnt_nx   = BW'(1);
            idle_nx  = 1'b0;
         end
      end
      // After a forced burst exit rr_last is already PORT_DMA, which hands the next conflict to the core.
      rr_nx = g1 ? PORT_DMA : g0 ? PORT_CORE : rr_last;
      if (rst) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end
   end

   assign addr  = g1 ? p1_addr  : p0_addr;
   assign wdata = g1 ? p1_wdata : p0_wdata;
   assign we    = g1 ? p1_we    : p0_we;

   dmem_addr_check #(.AW(AW)) u_check (.addr(addr), .ok(ok), .word(word));

   assign acc       = (g0 || g1) && ok;
   assign p0_ready  = g0;
   assign p1_ready  = g1;
   assign mem_read  = acc && !we;
   assign mem_write = acc && we;
   assign mem_addr  = acc ? word  : '0;
   assign mem_wdata = acc ? wdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_last   <= PORT_DMA;
         cnt       <= '0;
         idle      <= 1'b0;
         p0_rvalid <= 1'b0;
         p0_err    <= 1'b0;
         p0_rdata  <= '0;
         p1_rvalid <= 1'b0;
         p1_err    <= 1'b0;
         p1_rdata  <= '0;
      end else begin
         state     <= state_nx;
         rr_last   <= rr_nx;
         cnt       <= cnt_nx;
         idle      <= idle_nx;
         p0_rvalid <= g0;
         p0_err    <= g0 && !ok;
         p0_rdata  <= (g0 && acc && !we) ? mem_rdata : '0;
         p1_rvalid <= g1;
         p1_err    <= g1 && !ok;
         p1_rdata  <= (g1 && acc && !we) ? mem_rdata : '0;
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port 0) and a DMA/debug loader (port 1).
- Each port uses a valid/ready request handshake and gets a registered response one cycle later.
- Sits between the requesters and the data memory, and drives its MemRead, MemWrite, address and write_data inputs.
- Performs byte-to-word address conversion, alignment and range checking, round-robin arbitration, and bounded DMA burst locking.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory.
- AW, 6, memory word-index width; equals clog2(DEPTH).
- MAX_BURST, 8, maximum consecutive DMA grants while dma_lock is held.
- CORE_PRIO, 1, 1 = port 0 wins every conflict outside a DMA lock; 0 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- p0_valid  in  1  core request valid
- p0_ready  out  1  core request accepted this cycle
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  32  core byte address
- p0_wdata  in  32  core write data
- p0_rvalid  out  1  core response valid
- p0_rdata  out  32  core read data (0 for writes and errors)
- p0_err  out  1  core response error (misaligned or out of range)
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rvalid, p1_rdata, p1_err: same as port 0, for DMA
- dma_lock  in  1  DMA requests back-to-back ownership
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  32  word index, zero-extended from AW bits
- mem_wdata  out  32  to memory write_data
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async, rst=1): all outputs 0. State IDLE, rr_last=1 (port 0 favoured first), burst_cnt=0. The arbiter never drives mem_write while rst is high.
- Acceptance: port n is accepted when pn_valid && pn_ready. At most one port is ready per cycle. pn_ready is combinational from valids, state and rr_last.
- Request stability: a requester holds valid, we, addr and wdata until ready is seen.
- Decode of the accepted request:
  - word = addr[AW+1:2].
  - Error if addr[1:0]!=0 or addr[31:AW+2]!=0.
  - If error: mem_read=mem_write=0, no memory access, response has err=1 and rdata=0.
  - If valid: mem_read=!we, mem_write=we, mem_addr=word, mem_wdata=wdata, all in the same cycle. The write commits at that clk edge.
- Response:
  - pn_rvalid pulses exactly one cycle after acceptance.
  - pn_rdata holds mem_rdata registered at the accept edge for reads, else 0.
  - A port may issue its next request in the same cycle as its rvalid, which gives one access per cycle per port.
- FSM states: IDLE, SERVE, LOCK.
  - IDLE/SERVE, one valid: grant it.
  - IDLE/SERVE, both valid: CORE_PRIO=1 grants port 0; CORE_PRIO=0 grants the port other than rr_last.
  - On every grant: rr_last = granted port. Next state is SERVE if any valid, else IDLE.
  - Enter LOCK when port 1 is granted with dma_lock=1. burst_cnt=1 at that grant.
  - LOCK: only port 1 can be granted; p0_ready=0. Each port 1 grant increments burst_cnt.
  - Leave LOCK to SERVE (burst_cnt cleared) when any of these holds:
    - dma_lock=0 in a cycle;
    - burst_cnt==MAX_BURST after a grant;
    - p1_valid=0 for 2 consecutive cycles (idle timeout).
  - On a forced exit at MAX_BURST, rr_last=1 and port 0 gets the next conflict even if CORE_PRIO=0. This guarantees no core starvation beyond MAX_BURST+1 cycles.
- Simultaneous events: a write by one port and a read by the other to the same word are never concurrent, since only one access happens per cycle. A later read returns the new data.
- Reset mid-operation: pending rvalids are dropped (0) and LOCK is abandoned. Requesters must reissue.
- Width rules: mem_addr = {(32-AW) zeros, word}. No byte enables; only full-word access.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, SERVE, LOCK};
  - PORT_CORE=0 and PORT_DMA=1;
  - function addr_ok(addr, AW) and function word_idx(addr, AW).
- Sub-module dmem_addr_check: purely combinational alignment/range check and word index. Instantiated once, on the muxed granted address.

Test Plan:
- Reset: assert rst mid-LOCK with a pending read → all outputs 0 next sample, no rvalid; after release, p0 read of addr 0x0 → rvalid 1 cycle later, rdata=0.
- Basic RW: p0 writes 0xDEADBEEF to byte addr 0x10 → mem_addr=4, mem_write=1; p0 reads 0x10 next cycle → p0_rdata=0xDEADBEEF, p0_err=0.
- Errors: p1 read of 0x13 → p1_err=1, rdata=0, mem_read=0; p0 write to 0x100 (DEPTH=64) → p0_err=1, mem_write=0, memory unchanged.
- Arbitration with CORE_PRIO=0 and both valid for 4 cycles, no lock → grants alternate 0,1,0,1. With CORE_PRIO=1 → port 0 granted all 4 cycles.
- Burst limit: dma_lock=1, p1 and p0 continuously valid, MAX_BURST=8 → exactly 8 consecutive p1 grants, then a p0 grant, then LOCK re-entry is allowed.
- Lock release: dma_lock drops after 3 beats with p0 waiting → p0 granted the next cycle. p1_valid low 2 cycles in LOCK → state returns to SERVE/IDLE and p0_ready rises.
